// File: rtl/simon_seq_checker.sv
// Simon Says sequence checker: regenerates the LFSR colour stream from the seed and checks presses.
// Optional idle-timeout in CHECK is enabled by defining SEQ_CHECK_TIMEOUT_EN.
module simon_seq_checker #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seed,
  input  logic             start,
  input  logic [CNT_W-1:0] round_len,
  input  logic             btn_valid,
  input  logic [1:0]       btn_code,
  output logic             busy,
  output logic [1:0]       expected,
  output logic [CNT_W-1:0] press_idx,
  output logic             pass,
  output logic             fail,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, CHECK, PASS, FAIL} state_t;

  state_t           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

`ifdef SEQ_CHECK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    len_d   = len_q;
`ifdef SEQ_CHECK_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          lfsr_d  = seed;
          len_d   = (round_len == '0) ? CNT_W'(1) : round_len;
          idx_d   = '0;
          state_d = CHECK;
`ifdef SEQ_CHECK_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      CHECK: begin
        if (btn_valid) begin
`ifdef SEQ_CHECK_TIMEOUT_EN
          tcnt_d = '0;
`endif
          if (btn_code == lfsr_q[1:0]) begin
            if (idx_q == len_q - CNT_W'(1)) begin
              state_d = PASS;
            end else begin
              idx_d  = idx_q + CNT_W'(1);
              lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            end
          end else begin
            // lfsr and index are frozen so the miss can be inspected afterwards
            state_d = FAIL;
          end
        end
`ifdef SEQ_CHECK_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CYCLES)) begin
          state_d = FAIL;
          to_d    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      PASS:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    pass_d = (state_d == PASS);
    fail_d = (state_d == FAIL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= 8'h00;
      idx_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`ifdef SEQ_CHECK_TIMEOUT_EN
      tcnt_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
`ifdef SEQ_CHECK_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign expected  = lfsr_q[1:0];
  assign press_idx = idx_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
`ifdef SEQ_CHECK_TIMEOUT_EN
  assign timeout   = to_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_simon_seq_checker.sv
// Bench for simon_seq_checker: round-level reference model compared every cycle plus directed literal checks.
module tb_simon_seq_checker;
  localparam int CNT_W  = 4;
  localparam int TO_LIM = 16;
`ifdef SEQ_CHECK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       seed = 8'h00;
  logic             start = 1'b0;
  logic [CNT_W-1:0] round_len = '0;
  logic             btn_valid = 1'b0;
  logic [1:0]       btn_code = 2'd0;
  logic             busy, pass, fail, timeout;
  logic [1:0]       expected;
  logic [CNT_W-1:0] press_idx;

  int n_vec  = 0;
  int n_miss = 0;

  simon_seq_checker #(.TIMEOUT_CYCLES(TO_LIM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .seed(seed), .start(start), .round_len(round_len),
    .btn_valid(btn_valid), .btn_code(btn_code), .busy(busy), .expected(expected),
    .press_idx(press_idx), .pass(pass), .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // colour of press k in a round seeded with s
  function automatic logic [1:0] colour(input logic [7:0] s, input int k);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < k; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v[1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Round-level model: which press of which round we are on, plus pending result pulse
  bit         m_act, m_pass, m_fail, m_to;
  int         m_k, m_len, m_idle;
  logic [7:0] m_seed;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_pass = 0; m_fail = 0; m_to = 0;
      m_k = 0; m_len = 0; m_idle = 0; m_seed = 8'h00;
    end else if (m_pass || m_fail) begin
      m_pass = 0; m_fail = 0; m_to = 0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; m_seed = seed; m_k = 0; m_idle = 0;
        m_len = (round_len == 0) ? 1 : int'(round_len);
      end
    end else if (btn_valid) begin
      m_idle = 0;
      if (btn_code == colour(m_seed, m_k)) begin
        if (m_k == m_len - 1) begin m_act = 0; m_pass = 1; end
        else m_k++;
      end else begin
        m_act = 0; m_fail = 1;
      end
    end else if (TO_EN && m_idle == TO_LIM) begin
      m_act = 0; m_fail = 1; m_to = 1;
    end else begin
      m_idle++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'(m_act | m_pass | m_fail));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("fail", 32'(fail), 32'(m_fail));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("expected", 32'(expected), 32'(colour(m_seed, m_k)));
      chk("press_idx", 32'(press_idx), 32'(m_k));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] s, input logic [CNT_W-1:0] len);
    @(negedge clk);
    seed = s; round_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // returns at the first negedge after the sampling edge
  task automatic press(input logic [1:0] code);
    @(negedge clk);
    btn_valid = 1'b1; btn_code = code;
    @(negedge clk);
    btn_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    idle(3);
    #1 chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(press_idx), 0);
    chk("rst_expected", 32'(expected), 0);
    chk("rst_pass_fail", 32'({pass, fail, timeout}), 0);
    @(negedge clk) rst = 1'b0;
    idle(2);

    // full round of 3
    do_start(8'hB4, 4'd3);
    chk("r1_exp0", 32'(expected), 0);
    idle(2); press(2'd0);
    chk("r1_exp1", 32'(expected), 1);
    chk("r1_idx1", 32'(press_idx), 1);
    idle(2); press(2'd1);
    chk("r1_exp2", 32'(expected), 2);
    chk("r1_idx2", 32'(press_idx), 2);
    idle(1); press(2'd2);
    chk("r1_pass", 32'(pass), 1);
    chk("r1_busy_in_pass", 32'(busy), 1);
    @(negedge clk);
    chk("r1_busy_drop", 32'(busy), 0);

    // wrong second press
    do_start(8'hB4, 4'd4);
    press(2'd0); press(2'd3);
    chk("r2_fail", 32'(fail), 1);
    chk("r2_no_pass", 32'(pass), 0);
    chk("r2_exp_hold", 32'(expected), 1);
    chk("r2_idx_hold", 32'(press_idx), 1);
    idle(3);

    // zero length treated as one; start during PASS ignored
    do_start(8'hB4, 4'd0);
    press(2'd0);
    chk("r3_pass_len0", 32'(pass), 1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("r3_start_in_pass_ignored", 32'(busy), 0);
    idle(2);

    // press in IDLE ignored, start in CHECK ignored
    press(2'd0);
    chk("r4_idle_press", 32'(busy), 0);
    do_start(8'hB4, 4'd3);
    press(2'd0);
    do_start(8'h55, 4'd7);
    chk("r4_restart_idx", 32'(press_idx), 1);
    chk("r4_restart_exp", 32'(expected), 1);
    press(2'd1); press(2'd2);
    chk("r4_pass", 32'(pass), 1);
    idle(2);

    // async reset mid-round
    do_start(8'hB4, 4'd3);
    press(2'd0);
    idle(1);
    #3 rst = 1'b1;
    #1 chk("r5_rst_busy", 32'(busy), 0);
    chk("r5_rst_idx", 32'(press_idx), 0);
    chk("r5_rst_exp", 32'(expected), 0);
    chk("r5_rst_pulses", 32'({pass, fail, timeout}), 0);
    idle(2);
    rst = 1'b0;
    idle(2);
    chk("r5_after_rst_idle", 32'(busy), 0);
    do_start(8'hB4, 4'd3);
    chk("r5_restart_exp", 32'(expected), 0);
    press(2'd0); press(2'd1); press(2'd2);
    chk("r5_pass", 32'(pass), 1);
    idle(2);

    // all-zero seed and a longer model-driven round
    do_start(8'h00, 4'd3);
    press(2'd0); press(2'd0); press(2'd0);
    chk("r6_zero_pass", 32'(pass), 1);
    do_start(8'hC3, 4'd15);
    for (int i = 0; i < 15; i++) press(colour(8'hC3, i));
    chk("r7_long_pass", 32'(pass), 1);
    idle(2);

`ifdef SEQ_CHECK_TIMEOUT_EN
    do_start(8'hB4, 4'd3);
    idle(TO_LIM);
    chk("to_not_yet", 32'(fail), 0);
    @(negedge clk);
    chk("to_fail", 32'(fail), 1);
    chk("to_timeout", 32'(timeout), 1);
    idle(2);
    do_start(8'hB4, 4'd3);
    idle(TO_LIM - 1);
    press(2'd0);
    chk("to_press_wins_fail", 32'(fail), 0);
    chk("to_press_wins_idx", 32'(press_idx), 1);
    idle(TO_LIM + 4);
`else
    do_start(8'hB4, 4'd3);
    idle(40);
    chk("nto_still_busy", 32'(busy), 1);
    chk("nto_no_fail", 32'({fail, timeout}), 0);
    press(2'd0); press(2'd1); press(2'd2);
    chk("nto_pass", 32'(pass), 1);
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/simon_seq_checker.md
Name: simon_seq_checker

Overview:
Consumer end of the Simon Says pseudo-random colour stream. It regenerates the same 8-bit LFSR sequence from the shared seed and checks the player's button presses against it, press by press. It sits between the button debouncer/encoder and the game controller, and reports per-round pass/fail.

Parameters:
TIMEOUT_CYCLES, 1000, CHECK-state idle cycles allowed between presses (used only with the optional feature); must be >= 2
CNT_W, 4, width of round_len and press_idx

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
seed  input  8  same seed value given to the sequence generator; sampled on start
start  input  1  one-cycle pulse; begins checking a round
round_len  input  CNT_W  presses expected this round; sampled on start; 0 is treated as 1
btn_valid  input  1  one-cycle strobe: a button press is present
btn_code  input  2  colour of the pressed button, 0..3
busy  output  1  high while a round is being checked
expected  output  2  colour expected for the next press, equal to lfsr[1:0]
press_idx  output  CNT_W  number of correct presses so far in this round
pass  output  1  one-cycle pulse: round completed correctly
fail  output  1  one-cycle pulse: wrong press (or timeout)
timeout  output  1  one-cycle pulse, coincident with fail, when the failure was caused by timeout

Behaviour:
- Reset is asynchronous. All of the following clear immediately on reset: FSM=IDLE, lfsr=8'h00, press_idx=0, len_q=0, busy=0, pass=0, fail=0, timeout=0, expected=0, timeout counter=0.
- The LFSR step is bit-identical to the generator: next = {s[6:0], s[7]^s[5]^s[4]^s[3]}.
- Expected colour for press k is s_k[1:0], where s_0 = seed and s_{k+1} = step(s_k).
- An all-zero state stays zero: every expected colour is then 0. No reseed occurs.
- FSM states: IDLE, CHECK, PASS, FAIL.
- IDLE:
  - busy=0.
  - start=1 → lfsr<=seed, len_q<=(round_len==0 ? 1 : round_len), press_idx<=0, go to CHECK.
  - btn_valid is ignored.
- CHECK:
  - busy=1.
  - start is ignored; the round is not restarted.
  - btn_valid=1 and btn_code==expected and press_idx==len_q-1 → go to PASS.
  - btn_valid=1 and btn_code==expected otherwise → press_idx+1 and lfsr<=step(lfsr). Stay in CHECK.
  - btn_valid=1 and btn_code!=expected → go to FAIL. lfsr and press_idx hold their values for debug.
- PASS: pass=1 for exactly one cycle, busy=1, then IDLE. start and btn_valid are ignored.
- FAIL: fail=1 for exactly one cycle, busy=1, then IDLE. start and btn_valid are ignored.
- Latency: pass/fail rise in the cycle after the clock edge that samples the deciding btn_valid.
- pass and fail are registered state decodes. They are never high together.
- press_idx never exceeds len_q-1 in CHECK. No wrap-around is possible.
- Reset mid-round aborts the round with no pass/fail pulse. A new start is required afterwards.
- Back-to-back rounds: start is accepted no earlier than the cycle after the pass/fail pulse, when the FSM is in IDLE.

Optional Feature:
Macro SEQ_CHECK_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to CHECK and on every btn_valid accepted in CHECK.
  - The counter increments on every other CHECK cycle.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to FAIL, and fail and timeout pulse together for one cycle.
  - If btn_valid arrives in the same cycle the limit is reached, the press wins and is evaluated normally.
- Not defined: no counter logic. The timeout port remains, tied to 0. CHECK waits indefinitely.

Test Plan:
- Reset then seed=8'hB4, round_len=3, start; presses 0,1,2 one per few cycles → expected shows 0,1,2; press_idx steps 0→1→2; pass pulses one cycle after the third press; busy drops the cycle after that.
- seed=8'hB4, round_len=4, start; presses 0,3 → fail pulses once after the second press; expected stays 1; press_idx=1; no pass.
- seed=8'hB4, round_len=0, start; press 0 → pass after the single press (length treated as 1).
- btn_valid with btn_code=0 while IDLE, and start during CHECK (after press 0, round_len=3) → no state change; press_idx stays 1; the round continues and passes with presses 1,2.
- rst asserted asynchronously mid-CHECK after one correct press → busy, press_idx, expected go to 0 immediately with no pass/fail; a new start with seed 8'hB4 expects 0 again.
- SEQ_CHECK_TIMEOUT_EN, TIMEOUT_CYCLES=16: start, no presses → fail and timeout pulse together 17 cycles after start. Repeat with a correct press exactly at the limit cycle → no timeout; press_idx increments.
